// File: rtl/cpu_pkg.sv
// Shared CPU package: operation codes understood by the operand stack and
// the sticky trap codes it reports. The CPU decoder uses the same constants
// so both sides agree on the encoding.
package cpu_pkg;

  localparam int OP_W   = 3;
  localparam int TRAP_W = 2;

  // Operand stack operation codes; 5..7 are reserved and behave as NOP.
  localparam logic [OP_W-1:0] OP_NOP       = 3'd0;
  localparam logic [OP_W-1:0] OP_PUSH      = 3'd1;
  localparam logic [OP_W-1:0] OP_POP       = 3'd2;
  localparam logic [OP_W-1:0] OP_REPLACE   = 3'd3;
  localparam logic [OP_W-1:0] OP_POP2_PUSH = 3'd4;

  // Sticky trap codes; the first non-zero code freezes the stack.
  localparam logic [TRAP_W-1:0] TRAP_NONE      = 2'd0;
  localparam logic [TRAP_W-1:0] TRAP_UNDERFLOW = 2'd1;
  localparam logic [TRAP_W-1:0] TRAP_OVERFLOW  = 2'd2;

endpackage

// File: rtl/operand_stack.sv
// Operand stack for a stack-machine CPU (wasm style).
// One operation per rising clk edge, results visible from the next edge.
//
// Ports:
//   clk      - clock, rising edge active
//   reset    - asynchronous, active-low reset
//   op       - operation code (cpu_pkg OP_*)
//   data_in  - value written by PUSH / REPLACE / POP2_PUSH
//   top      - entry at the top of the stack (0 when empty)
//   next     - entry directly below top (0 when fewer than two entries)
//   count    - number of valid entries
//   empty    - count == 0
//   full     - count == DEPTH
//   trap     - sticky error code (cpu_pkg TRAP_*)
module operand_stack
  import cpu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [OP_W-1:0]            op,
  input  logic [WIDTH-1:0]           data_in,
  output logic [WIDTH-1:0]           top,
  output logic [WIDTH-1:0]           next,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full,
  output logic [TRAP_W-1:0]          trap
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [CW-1:0] TWO_C   = CW'(2);

  logic [WIDTH-1:0]  stack_q [DEPTH];
  logic [CW-1:0]     sp_q, sp_d;
  logic [TRAP_W-1:0] trap_q, trap_d;

  logic              wrEn;
  logic [AW-1:0]     wrAddr;
  logic [AW-1:0]     topIdx;
  logic [AW-1:0]     nextIdx;

  // sp_q points one past the top entry; the low bits wrap harmlessly
  // because the read is masked whenever the slot is not valid.
  assign topIdx  = sp_q[AW-1:0] - AW'(1);
  assign nextIdx = sp_q[AW-1:0] - AW'(2);

  // Next-state decode. A failing op records its trap code and leaves
  // storage and count alone; once trapped, everything is ignored.
  always_comb begin
    sp_d   = sp_q;
    trap_d = trap_q;
    wrEn   = 1'b0;
    wrAddr = sp_q[AW-1:0];
    if (trap_q == TRAP_NONE) begin
      case (op)
        OP_PUSH: begin
          if (sp_q == DEPTH_C) begin
            trap_d = TRAP_OVERFLOW;
          end else begin
            wrEn   = 1'b1;
            wrAddr = sp_q[AW-1:0];
            sp_d   = sp_q + ONE_C;
          end
        end
        OP_POP: begin
          if (sp_q == '0) begin
            trap_d = TRAP_UNDERFLOW;
          end else begin
            sp_d = sp_q - ONE_C;
          end
        end
        OP_REPLACE: begin
          if (sp_q == '0) begin
            trap_d = TRAP_UNDERFLOW;
          end else begin
            wrEn   = 1'b1;
            wrAddr = topIdx;
          end
        end
        OP_POP2_PUSH: begin
          // Result lands in the slot that held next; net one entry fewer.
          if (sp_q < TWO_C) begin
            trap_d = TRAP_UNDERFLOW;
          end else begin
            wrEn   = 1'b1;
            wrAddr = nextIdx;
            sp_d   = sp_q - ONE_C;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Stack pointer and trap state; reset forces an empty, untrapped stack.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp_q   <= '0;
      trap_q <= TRAP_NONE;
    end else begin
      sp_q   <= sp_d;
      trap_q <= trap_d;
    end
  end

  // Storage is never cleared; the outputs are masked by count instead.
  always_ff @(posedge clk) begin
    if (wrEn) begin
      stack_q[wrAddr] <= data_in;
    end
  end

  assign top   = (sp_q == '0)   ? '0 : stack_q[topIdx];
  assign next  = (sp_q < TWO_C) ? '0 : stack_q[nextIdx];
  assign count = sp_q;
  assign empty = (sp_q == '0);
  assign full  = (sp_q == DEPTH_C);
  assign trap  = trap_q;

endmodule
